// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake, optional skid entry and flush.
// Carries a control field (zeroed on flush), NCH data channels and a tag, unmodified.
module pipe_reg_skid #(
    parameter int unsigned DW    = 32,
    parameter int unsigned NCH   = 3,
    parameter int unsigned TW    = 6,
    parameter int unsigned CW    = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_ctrl,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [TW-1:0]     in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_ctrl,
    output logic [NCH*DW-1:0] out_data,
    output logic [TW-1:0]     out_tag,
    output logic [1:0]        occ,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned PW      = CW + NCH * DW + TW;
    localparam bit          UseSkid = (DEPTH == 2);

    logic [PW-1:0] in_beat;
    logic [PW-1:0] out_q, out_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [15:0]   stall_q, stall_d;
    logic          accept;

    assign in_beat = {in_ctrl, in_data, in_tag};

    // With a skid entry in_ready depends only on state, breaking the out_ready -> in_ready path.
    assign in_ready = UseSkid ? ~skid_valid_q : (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d       = 1'b0;
            skid_valid_d      = 1'b0;
            out_d[PW-1 -: CW] = '0;
        end else if (~out_valid_q | out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_beat;
                end
            end else if (accept) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
        if (!UseSkid) begin
            skid_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_q      <= stall_d;
        end
    end

    assign {out_ctrl, out_data, out_tag} = out_q;
    assign out_valid = out_valid_q;
    assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: DEPTH=2 vector table plus hand sequences for
// stall saturation, asynchronous reset and the DEPTH=1 variant.
module tb_pipe_reg_skid;

    localparam int unsigned DW  = 8;
    localparam int unsigned NCH = 3;
    localparam int unsigned TW  = 6;
    localparam int unsigned CW  = 5;
    localparam int unsigned BW  = NCH * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=2 instance signals
    logic          iv2, ir2, fl2, ov2, or2;
    logic [CW-1:0] ic2, oc2;
    logic [BW-1:0] id2, od2;
    logic [TW-1:0] it2, ot2;
    logic [1:0]    occ2;
    logic [15:0]   st2;

    // DEPTH=1 instance signals
    logic          iv1, ir1, fl1, ov1, or1;
    logic [CW-1:0] ic1, oc1;
    logic [BW-1:0] id1, od1;
    logic [TW-1:0] it1, ot1;
    logic [1:0]    occ1;
    logic [15:0]   st1;

    pipe_reg_skid #(.DW(DW), .NCH(NCH), .TW(TW), .CW(CW), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_ctrl(ic2),
        .in_data(id2), .in_tag(it2), .flush(fl2), .out_valid(ov2), .out_ready(or2),
        .out_ctrl(oc2), .out_data(od2), .out_tag(ot2), .occ(occ2), .stall_cnt(st2)
    );

    pipe_reg_skid #(.DW(DW), .NCH(NCH), .TW(TW), .CW(CW), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1),
        .in_data(id1), .in_tag(it1), .flush(fl1), .out_valid(ov1), .out_ready(or1),
        .out_ctrl(oc1), .out_data(od1), .out_tag(ot1), .occ(occ1), .stall_cnt(st1)
    );

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic [BW-1:0] d;
        logic [CW-1:0] c;
        logic          e_ov;
        logic [BW-1:0] e_od;
        logic [CW-1:0] e_oc;
        logic          e_ir;
        logic [1:0]    e_occ;
        logic [15:0]   e_st;
    } vec_t;

    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // inputs, then post-edge expectations: out_valid, out_data, out_ctrl, in_ready, occ, stall
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 24'h11, 5'h01, 1'b1, 24'h11, 5'h01, 1'b1, 2'd1, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 24'h22, 5'h02, 1'b1, 24'h22, 5'h02, 1'b1, 2'd1, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 24'h33, 5'h03, 1'b1, 24'h33, 5'h03, 1'b1, 2'd1, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 24'h00, 5'h00, 1'b0, 24'h33, 5'h03, 1'b1, 2'd0, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 24'h0A, 5'h0A, 1'b1, 24'h0A, 5'h0A, 1'b1, 2'd1, 16'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 24'h0B, 5'h0B, 1'b1, 24'h0A, 5'h0A, 1'b0, 2'd2, 16'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 24'h00, 5'h00, 1'b1, 24'h0B, 5'h0B, 1'b1, 2'd1, 16'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 24'h00, 5'h00, 1'b0, 24'h0B, 5'h0B, 1'b1, 2'd0, 16'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 24'h44, 5'h04, 1'b1, 24'h44, 5'h04, 1'b1, 2'd1, 16'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 24'h55, 5'h05, 1'b1, 24'h44, 5'h04, 1'b0, 2'd2, 16'd2};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 24'h66, 5'h06, 1'b0, 24'h44, 5'h00, 1'b1, 2'd0, 16'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 24'h00, 5'h00, 1'b0, 24'h44, 5'h00, 1'b1, 2'd0, 16'd2};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 24'h77, 5'h07, 1'b0, 24'h44, 5'h00, 1'b1, 2'd0, 16'd2};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 24'h88, 5'h08, 1'b1, 24'h88, 5'h08, 1'b1, 2'd1, 16'd2};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 24'h00, 5'h00, 1'b1, 24'h88, 5'h08, 1'b1, 2'd1, 16'd3};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 24'h00, 5'h00, 1'b0, 24'h88, 5'h08, 1'b1, 2'd0, 16'd3};

        iv2 = 1'b0; or2 = 1'b0; fl2 = 1'b0; id2 = '0; ic2 = '0; it2 = '0;
        iv1 = 1'b0; or1 = 1'b0; fl1 = 1'b0; id1 = '0; ic1 = '0; it1 = '0;

        // Reset state
        #2;
        chk("rst_ov", 32'(ov2), 32'd0);
        chk("rst_ir", 32'(ir2), 32'd1);
        chk("rst_occ", 32'(occ2), 32'd0);
        chk("rst_od", 32'(od2), 32'd0);
        chk("rst_oc", 32'(oc2), 32'd0);
        chk("rst_st", 32'(st2), 32'd0);
        chk("rst_ir_d1", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            iv2 = vecs[i].iv; or2 = vecs[i].ordy; fl2 = vecs[i].fl;
            id2 = vecs[i].d;  ic2 = vecs[i].c;    it2 = vecs[i].d[TW-1:0];
            @(posedge clk); #1;
            chk($sformatf("v%0d_ov", i), 32'(ov2), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_od", i), 32'(od2), 32'(vecs[i].e_od));
            chk($sformatf("v%0d_ot", i), 32'(ot2), 32'(vecs[i].e_od[TW-1:0]));
            chk($sformatf("v%0d_oc", i), 32'(oc2), 32'(vecs[i].e_oc));
            chk($sformatf("v%0d_ir", i), 32'(ir2), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d_occ", i), 32'(occ2), 32'(vecs[i].e_occ));
            chk($sformatf("v%0d_st", i), 32'(st2), 32'(vecs[i].e_st));
        end

        // Long stall: counter saturates and holds
        iv2 = 1'b1; or2 = 1'b0; id2 = 24'h99; ic2 = 5'h09; it2 = 6'h19;
        @(posedge clk); #1;
        iv2 = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_st", 32'(st2), 32'hFFFF);
        chk("sat_od", 32'(od2), 32'h99);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", 32'(st2), 32'hFFFF);

        // Fill the skid, then pulse reset between edges
        iv2 = 1'b1; id2 = 24'hAA; ic2 = 5'h0A;
        @(posedge clk); #1;
        iv2 = 1'b0;
        chk("pre_rst_occ", 32'(occ2), 32'd2);
        #3 rst = 1'b1;
        #1;
        chk("arst_ov", 32'(ov2), 32'd0);
        chk("arst_occ", 32'(occ2), 32'd0);
        chk("arst_od", 32'(od2), 32'd0);
        chk("arst_ot", 32'(ot2), 32'd0);
        chk("arst_oc", 32'(oc2), 32'd0);
        chk("arst_st", 32'(st2), 32'd0);
        chk("arst_ir", 32'(ir2), 32'd1);
        #1 rst = 1'b0;
        iv2 = 1'b1; or2 = 1'b1; id2 = 24'hBB; ic2 = 5'h0B; it2 = 6'h3B;
        @(posedge clk); #1;
        iv2 = 1'b0;
        chk("post_rst_ov", 32'(ov2), 32'd1);
        chk("post_rst_od", 32'(od2), 32'hBB);
        chk("post_rst_ot", 32'(ot2), 32'h3B);

        // DEPTH=1: in_ready mirrors out_ready while full
        iv1 = 1'b1; or1 = 1'b1; id1 = 24'hD1; ic1 = 5'h11; #1;
        chk("d1_s0_ir", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        chk("d1_s0_od", 32'(od1), 32'hD1);
        chk("d1_s0_ov", 32'(ov1), 32'd1);
        id1 = 24'hD2; ic1 = 5'h12; #1;
        chk("d1_s1_ir", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        chk("d1_s1_od", 32'(od1), 32'hD2);
        or1 = 1'b0; id1 = 24'hD3; ic1 = 5'h13; #1;
        chk("d1_s2_ir", 32'(ir1), 32'd0);
        @(posedge clk); #1;
        chk("d1_s2_od", 32'(od1), 32'hD2);
        chk("d1_s2_st", 32'(st1), 32'd1);
        or1 = 1'b1; #1;
        chk("d1_s3_ir", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        chk("d1_s3_od", 32'(od1), 32'hD3);
        chk("d1_s3_oc", 32'(oc1), 32'h13);
        iv1 = 1'b0;
        @(posedge clk); #1;
        chk("d1_s4_ov", 32'(ov1), 32'd0);
        chk("d1_s4_od", 32'(od1), 32'hD3);
        chk("d1_s4_occ", 32'(occ1), 32'd0);
        iv1 = 1'b1; fl1 = 1'b1; id1 = 24'hD4; ic1 = 5'h14;
        @(posedge clk); #1;
        iv1 = 1'b0; fl1 = 1'b0;
        chk("d1_fl_ov", 32'(ov1), 32'd0);
        chk("d1_fl_oc", 32'(oc1), 32'd0);
        chk("d1_fl_od", 32'(od1), 32'hD3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
